// File: rtl/hw_chain_frame_driver_if.sv
// Request/status bundle between the display formatter
// and the chained shift-register frame driver.
interface hw_chain_frame_driver_if #(
  parameter int REG_SIZE     = 8,
  parameter int NUM_DATA_REG = 6,
  parameter int CTRL_SIZE    = 8
);
  logic ena;
  logic auto_mode;
  logic [NUM_DATA_REG-1:0][REG_SIZE-1:0] dig_data_in;
  logic [CTRL_SIZE-1:0] ctrl_data_in;
  logic upd_req;
  logic upd_ack;
  logic busy;
  logic frame_done;

  modport master (
    output ena, auto_mode, dig_data_in,
    output ctrl_data_in, upd_req,
    input  upd_ack, busy, frame_done
  );

  modport slave (
    input  ena, auto_mode, dig_data_in,
    input  ctrl_data_in, upd_req,
    output upd_ack, busy, frame_done
  );
endinterface

// File: rtl/hw_chain_frame_driver.sv
// Serialises digit + control frames into daisy-chained
// 595-style registers on a prescaled bit clock.
module hw_chain_frame_driver #(
  parameter int REG_SIZE          = 8,
  parameter int NUM_DATA_REG      = 6,
  parameter int CTRL_SIZE         = 8,
  parameter int CLK_PRESCALER     = 1000,
  parameter int CYCLES_PER_UPDATE = 100,
  parameter bit MSB_FIRST         = 1'b1,
  parameter bit SKIP_UNCHANGED    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  hw_chain_frame_driver_if.slave bus,
  output logic all_bit_clk,
  output logic all_nrst,
  output logic control_data_ser,
  output logic digit_data_ser,
  output logic control_reg_clk
);
  localparam int F  = NUM_DATA_REG * REG_SIZE;
  localparam int PW = CLK_PRESCALER > 1 ?
                      $clog2(CLK_PRESCALER) : 1;
  localparam int UW = $clog2(CYCLES_PER_UPDATE + 1);
  localparam int KW = F > 1 ? $clog2(F) : 1;

  typedef enum logic [1:0] {
    CLR, IDLE, SHIFT, LATCH
  } state_t;

  state_t state;
  logic [PW-1:0] pcnt;
  logic [UW-1:0] period;
  logic [KW-1:0] k;
  logic ph;
  logic pending;
  logic [F-1:0] last_dig;
  logic [CTRL_SIZE-1:0] last_ctrl;
  logic [F-1:0] dsr;
  logic [F-1:0] csr;

  logic [F-1:0] flat;
  logic [F-1:0] dord;
  logic [F-1:0] cord;
  logic tick;
  logic go;
  logic skip;

  assign flat = bus.dig_data_in;
  assign tick = pcnt == PW'(CLK_PRESCALER - 1);

  // Reorder so every frame shifts out of the MSB end.
  always_comb begin
    dord = '0;
    cord = '0;
    for (int r = 0; r < NUM_DATA_REG; r++)
      for (int b = 0; b < REG_SIZE; b++)
        dord[r*REG_SIZE+b] = MSB_FIRST ?
          flat[r*REG_SIZE+b] :
          flat[r*REG_SIZE+REG_SIZE-1-b];
    for (int b = 0; b < CTRL_SIZE; b++)
      cord[b] = MSB_FIRST ?
        bus.ctrl_data_in[b] :
        bus.ctrl_data_in[CTRL_SIZE-1-b];
  end

  assign go = state == IDLE && bus.ena &&
              (bus.upd_req || pending ||
               (bus.auto_mode && period == '0));
  assign skip = SKIP_UNCHANGED &&
                !bus.upd_req && !pending &&
                flat == last_dig &&
                bus.ctrl_data_in == last_ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= CLR;
      pcnt             <= '0;
      period           <= '0;
      k                <= '0;
      ph               <= 1'b0;
      pending          <= 1'b0;
      last_dig         <= '0;
      last_ctrl        <= '0;
      dsr              <= '0;
      csr              <= '0;
      all_bit_clk      <= 1'b0;
      all_nrst         <= 1'b0;
      control_data_ser <= 1'b0;
      digit_data_ser   <= 1'b0;
      control_reg_clk  <= 1'b0;
      bus.upd_ack      <= 1'b0;
      bus.busy         <= 1'b0;
      bus.frame_done   <= 1'b0;
    end else begin
      bus.upd_ack    <= 1'b0;
      bus.frame_done <= 1'b0;
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick && period != '0)
        period <= period - 1'b1;
      if (bus.upd_req &&
          (state == SHIFT || state == LATCH))
        pending <= 1'b1;
      unique case (state)
        CLR: if (tick) begin
          if (ph) begin
            all_nrst <= 1'b1;
            ph       <= 1'b0;
            state    <= IDLE;
          end else begin
            ph <= 1'b1;
          end
        end
        IDLE: begin
          bus.busy <= 1'b0;
          if (go) begin
            period <= UW'(CYCLES_PER_UPDATE);
            if (!skip) begin
              pending     <= 1'b0;
              bus.upd_ack <= 1'b1;
              bus.busy    <= 1'b1;
              last_dig    <= flat;
              last_ctrl   <= bus.ctrl_data_in;
              dsr         <= dord;
              csr         <= cord;
              k           <= '0;
              ph          <= 1'b0;
              state       <= SHIFT;
            end
          end
        end
        SHIFT: if (tick) begin
          if (!ph) begin
            all_bit_clk      <= 1'b0;
            digit_data_ser   <= dsr[F-1];
            control_data_ser <= csr[F-1];
            ph               <= 1'b1;
          end else begin
            all_bit_clk <= 1'b1;
            dsr         <= dsr << 1;
            csr         <= csr << 1;
            ph          <= 1'b0;
            if (k == KW'(F - 1))
              state <= LATCH;
            else
              k <= k + 1'b1;
          end
        end
        LATCH: if (tick) begin
          if (!ph) begin
            all_bit_clk      <= 1'b0;
            digit_data_ser   <= 1'b0;
            control_data_ser <= 1'b0;
            control_reg_clk  <= 1'b1;
            ph               <= 1'b1;
          end else begin
            control_reg_clk <= 1'b0;
            bus.frame_done  <= 1'b1;
            ph              <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= CLR;
      endcase
    end
  end
endmodule

// File: tb/tb_hw_chain_frame_driver.sv
// Directed bench: models the 595 chains on the pins and
// checks frames, handshake, auto refresh and reset.
module tb_hw_chain_frame_driver;
  localparam logic [47:0] DA = 48'h41_49_99_0D_25_9F;
  localparam logic [47:0] DB = 48'h63_C1_11_09_01_1F;
  localparam logic [47:0] DC = 48'h12_34_56_78_9A_BC;
  localparam logic [47:0] DD = 48'h12_34_56_78_9A_BD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic all_bit_clk;
  logic all_nrst;
  logic control_data_ser;
  logic digit_data_ser;
  logic control_reg_clk;

  hw_chain_frame_driver_if #(
    .REG_SIZE(8), .NUM_DATA_REG(6), .CTRL_SIZE(8)
  ) bus ();

  hw_chain_frame_driver #(
    .REG_SIZE(8), .NUM_DATA_REG(6), .CTRL_SIZE(8),
    .CLK_PRESCALER(2), .CYCLES_PER_UPDATE(100),
    .MSB_FIRST(1'b1), .SKIP_UNCHANGED(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .all_bit_clk(all_bit_clk),
    .all_nrst(all_nrst),
    .control_data_ser(control_data_ser),
    .digit_data_ser(digit_data_ser),
    .control_reg_clk(control_reg_clk)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int ack_cyc = 0;
  int done_cyc = 0;
  int rises = 0;
  int rclk_cnt = 0;
  logic [47:0] dchain = '0;
  logic [47:0] cchain = '0;
  logic [7:0] control_q = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.upd_ack) begin
      ack_cnt++;
      ack_cyc = cyc;
    end
    if (bus.frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  always @(posedge all_bit_clk) begin
    dchain = {dchain[46:0], digit_data_ser};
    cchain = {cchain[46:0], control_data_ser};
    rises++;
  end

  always @(posedge control_reg_clk) begin
    control_q = cchain[7:0];
    rclk_cnt++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic pulse_req();
    @(negedge clk);
    bus.upd_req = 1'b1;
    @(negedge clk);
    bus.upd_req = 1'b0;
  endtask

  task automatic wait_frame(input string tag,
                            input int maxc);
    int d0 = done_cnt;
    int i = 0;
    while (done_cnt == d0 && i < maxc) begin
      @(posedge clk);
      i++;
    end
    check(tag, 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic wait_ack(input string tag,
                          input int maxc);
    int a0 = ack_cnt;
    int i = 0;
    while (ack_cnt == a0 && i < maxc) begin
      @(posedge clk);
      i++;
    end
    check(tag, 64'(ack_cnt != a0), 64'd1);
  endtask

  task automatic wait_rises(input string tag,
                            input int target,
                            input int maxc);
    int i = 0;
    while (rises < target && i < maxc) begin
      @(posedge clk);
      i++;
    end
    check(tag, 64'(rises >= target), 64'd1);
  endtask

  task automatic check_clr(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, "_nrst_low"}, 64'(all_nrst), 64'd0);
    end
    @(negedge clk);
    check({tag, "_nrst_high"}, 64'(all_nrst), 64'd1);
  endtask

  function automatic logic [7:0] pins();
    return {all_bit_clk, all_nrst, control_data_ser,
            digit_data_ser, control_reg_clk,
            bus.upd_ack, bus.busy, bus.frame_done};
  endfunction

  initial begin
    int base;
    int a0;
    int d0;
    int r0;
    int lat;
    bus.ena = 1'b1;
    bus.auto_mode = 1'b0;
    bus.dig_data_in = '0;
    bus.ctrl_data_in = '0;
    bus.upd_req = 1'b0;

    // 1: reset and clear sequence
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t1_reset_pins", 64'(pins()), 64'd0);
    rst = 1'b0;
    check_clr("t1");
    repeat (50) @(posedge clk);
    check("t1_no_bitclk", 64'(rises), 64'd0);

    // 2: one frame, MSB first
    @(negedge clk);
    bus.dig_data_in = DA;
    bus.ctrl_data_in = 8'hA5;
    base = rises;
    r0 = rclk_cnt;
    pulse_req();
    wait_rises("t2_reach8", base + 8, 100);
    check("t2_first_byte", 64'(dchain[7:0]), 64'h41);
    wait_frame("t2_done", 400);
    check("t2_rises", 64'(rises - base), 64'd48);
    check("t2_digits", 64'(dchain), 64'(DA));
    check("t2_rclk_pulses", 64'(rclk_cnt - r0), 64'd1);
    check("t2_control_q", 64'(control_q), 64'hA5);
    lat = done_cyc - ack_cyc;
    check("t2_latency", 64'(lat == 195 || lat == 196), 64'd1);
    @(negedge clk);
    check("t2_idle_pins", 64'(pins()), 64'h40);

    // 3: snapshot frozen mid-frame
    base = rises;
    pulse_req();
    wait_rises("t3_reach20", base + 20, 200);
    @(negedge clk);
    bus.dig_data_in = DB;
    wait_frame("t3_done_old", 400);
    check("t3_old_data", 64'(dchain), 64'(DA));
    pulse_req();
    wait_frame("t3_done_new", 400);
    check("t3_new_data", 64'(dchain), 64'(DB));

    // 4: auto refresh with skip-if-unchanged
    @(negedge clk);
    d0 = done_cnt;
    bus.dig_data_in = DC;
    bus.auto_mode = 1'b1;
    repeat (1000) @(posedge clk);
    check("t4_one_frame", 64'(done_cnt - d0), 64'd1);
    check("t4_auto_data", 64'(dchain), 64'(DC));
    @(negedge clk);
    bus.dig_data_in = DD;
    wait_ack("t4_change_start", 205);
    wait_frame("t4_change_done", 400);
    check("t4_changed_data", 64'(dchain), 64'(DD));
    d0 = done_cnt;
    repeat (600) @(posedge clk);
    check("t4_no_more", 64'(done_cnt - d0), 64'd0);
    @(negedge clk);
    bus.auto_mode = 1'b0;
    repeat (4) @(negedge clk);

    // 5: pending requests merge into one extra frame
    a0 = ack_cnt;
    base = rises;
    pulse_req();
    wait_rises("t5_reach10", base + 10, 200);
    for (int i = 0; i < 3; i++) begin
      pulse_req();
      repeat (5) @(negedge clk);
    end
    wait_frame("t5_done1", 400);
    d0 = done_cyc;
    wait_ack("t5_pending_ack", 4);
    check("t5_ack_after_done", 64'(ack_cyc - d0), 64'd1);
    wait_frame("t5_done2", 400);
    repeat (400) @(posedge clk);
    check("t5_two_frames", 64'(ack_cnt - a0), 64'd2);

    // 5b: ena low keeps pending until re-enabled
    base = rises;
    pulse_req();
    wait_rises("t5b_reach10", base + 10, 200);
    pulse_req();
    @(negedge clk);
    bus.ena = 1'b0;
    wait_frame("t5b_done", 400);
    a0 = ack_cnt;
    repeat (50) @(posedge clk);
    check("t5b_held", 64'(ack_cnt - a0), 64'd0);
    @(negedge clk);
    bus.ena = 1'b1;
    wait_ack("t5b_resume", 4);
    wait_frame("t5b_done2", 400);

    // 6: reset mid-frame
    base = rises;
    r0 = rclk_cnt;
    pulse_req();
    wait_rises("t6_reach20", base + 20, 200);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_pins_zero", 64'(pins()), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_clr("t6");
    repeat (40) @(posedge clk);
    check("t6_no_latch", 64'(rclk_cnt - r0), 64'd0);
    check("t6_idle", 64'(bus.busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
